cpu_mobo_master: RTL and testbench

//  Parametrised CPU-side motherboard bus master. Replaces hand-sequenced write/read test states in the CPU FSM.

---
 rtl/mobo_master_pkg.sv | 21 ++
 rtl/mobo_timeout.sv | 30 +++
 rtl/cpu_mobo_master.sv | 201 ++++++++++++++++++++
 tb/tb_cpu_mobo_master.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mobo_master_pkg.sv
// Shared types and mobo handshake codes for the CPU-side motherboard bus master.
// The CTRL_*/STAT_* values mirror mobo_states.v so CPU and mobo agree on the encoding.
package mobo_master_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WDATA,
      WAIT_IDLE,
      WAIT_DONE,
      RESP,
      NEXT
   } mm_state_t;

   localparam int unsigned CTRL_NONE  = 0;
   localparam int unsigned CTRL_READ  = 1;
   localparam int unsigned CTRL_WRITE = 2;

   localparam int unsigned STAT_IDLE  = 0;
   localparam int unsigned STAT_DONE  = 1;

endpackage

// File: rtl/mobo_timeout.sv
// Wait-state watchdog: counts cycles while enabled, flags expiry once the count reaches TIMEOUT.
// One instance serves both mobo wait states; the master clears it on every wait-state entry.
module mobo_timeout #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   logic [CW-1:0] count_q;

   assign expired = (count_q == CW'(TIMEOUT));

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (en && !expired) begin
         count_q <= count_q + CW'(1);
      end
   end

endmodule

// File: rtl/cpu_mobo_master.sv
// CPU-side motherboard bus master: takes one read/write burst request and runs the
// mobo_ctrl/mobo_stat handshake per beat with auto-increment and a timeout abort path.
module cpu_mobo_master
   import mobo_master_pkg::*;
#(
   parameter int unsigned WORD_WIDTH  = 16,
   parameter int unsigned LEN_WIDTH   = 4,
   parameter int unsigned ADDR_STRIDE = 1,
   parameter int unsigned TIMEOUT     = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [WORD_WIDTH-1:0] req_addr,
   input  logic [LEN_WIDTH-1:0]  req_len,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [WORD_WIDTH-1:0] wr_data,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [WORD_WIDTH-1:0] rsp_data,
   output logic                  rsp_last,
   output logic                  done,
   output logic                  err,
   output logic [WORD_WIDTH-1:0] mobo_ctrl,
   input  logic [WORD_WIDTH-1:0] mobo_stat,
   output logic [WORD_WIDTH-1:0] addr_out,
   output logic [WORD_WIDTH-1:0] mobodat_out,
   input  logic [WORD_WIDTH-1:0] mobodat_in
);

   localparam logic [WORD_WIDTH-1:0] C_NONE  = WORD_WIDTH'(CTRL_NONE);
   localparam logic [WORD_WIDTH-1:0] C_READ  = WORD_WIDTH'(CTRL_READ);
   localparam logic [WORD_WIDTH-1:0] C_WRITE = WORD_WIDTH'(CTRL_WRITE);
   localparam logic [WORD_WIDTH-1:0] S_IDLE  = WORD_WIDTH'(STAT_IDLE);
   localparam logic [WORD_WIDTH-1:0] S_DONE  = WORD_WIDTH'(STAT_DONE);
   localparam logic [WORD_WIDTH-1:0] STRIDE  = WORD_WIDTH'(ADDR_STRIDE);

   mm_state_t             state_q, state_d;
   logic                  write_q, write_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [LEN_WIDTH-1:0]  beat_q, beat_d;
   logic [WORD_WIDTH-1:0] addr_q, addr_d;
   logic [WORD_WIDTH-1:0] wdat_q, wdat_d;
   logic [WORD_WIDTH-1:0] ctrl_q, ctrl_d;
   logic [WORD_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_last_q, rsp_last_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  req_ready_q, req_ready_d;
   logic                  wr_ready_q, wr_ready_d;

   logic timer_clr, timer_en, timer_expired;

   assign timer_en  = (state_q == WAIT_IDLE) || (state_q == WAIT_DONE);
   assign timer_clr = (state_d != state_q) &&
                      ((state_d == WAIT_IDLE) || (state_d == WAIT_DONE));

   mobo_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clr     (timer_clr),
      .en      (timer_en),
      .expired (timer_expired)
   );

   always_comb begin
      // NOTE: every next-state signal is defaulted first so no path through the case infers a latch.
      state_d     = state_q;
      write_d     = write_q;
      len_d       = len_q;
      beat_d      = beat_q;
      addr_d      = addr_q;
      wdat_d      = wdat_q;
      ctrl_d      = ctrl_q;
      rsp_data_d  = rsp_data_q;
      rsp_valid_d = rsp_valid_q;
      rsp_last_d  = rsp_last_q;
      done_d      = 1'b0;
      err_d       = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_valid && req_ready_q) begin
               write_d = req_write;
               addr_d  = req_addr;
               len_d   = req_len;
               beat_d  = '0;
               state_d = req_write ? WDATA : WAIT_IDLE;
            end
         end
         WDATA: begin
            if (wr_valid) begin
               wdat_d  = wr_data;
               state_d = WAIT_IDLE;
            end
         end
         WAIT_IDLE: begin
            if (mobo_stat == S_IDLE) begin
               ctrl_d  = write_q ? C_WRITE : C_READ;
               state_d = WAIT_DONE;
            end else if (timer_expired) begin
               ctrl_d  = C_NONE;
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         WAIT_DONE: begin
            // STAT_DONE is tested first so it wins over a coincident timeout.
            if (mobo_stat == S_DONE) begin
               ctrl_d = C_NONE;
               if (write_q) begin
                  state_d = NEXT;
               end else begin
                  rsp_data_d  = mobodat_in;
                  rsp_valid_d = 1'b1;
                  rsp_last_d  = (beat_q == len_q);
                  state_d     = RESP;
               end
            end else if (timer_expired) begin
               ctrl_d  = C_NONE;
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               rsp_last_d  = 1'b0;
               state_d     = NEXT;
            end
         end
         NEXT: begin
            if (beat_q == len_q) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               addr_d  = addr_q + STRIDE;
               beat_d  = beat_q + LEN_WIDTH'(1);
               state_d = write_q ? WDATA : WAIT_IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Ready flags are registered from the state being entered so they line up with it.
      req_ready_d = (state_d == IDLE);
      wr_ready_d  = (state_d == WDATA);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         write_q     <= 1'b0;
         len_q       <= '0;
         beat_q      <= '0;
         addr_q      <= '0;
         wdat_q      <= '0;
         ctrl_q      <= C_NONE;
         rsp_data_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_last_q  <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         req_ready_q <= 1'b0;
         wr_ready_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         write_q     <= write_d;
         len_q       <= len_d;
         beat_q      <= beat_d;
         addr_q      <= addr_d;
         wdat_q      <= wdat_d;
         ctrl_q      <= ctrl_d;
         rsp_data_q  <= rsp_data_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_last_q  <= rsp_last_d;
         done_q      <= done_d;
         err_q       <= err_d;
         req_ready_q <= req_ready_d;
         wr_ready_q  <= wr_ready_d;
      end
   end

   assign req_ready   = req_ready_q;
   assign wr_ready    = wr_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_last    = rsp_last_q;
   assign done        = done_q;
   assign err         = err_q;
   assign mobo_ctrl   = ctrl_q;
   assign addr_out    = addr_q;
   assign mobodat_out = wdat_q;

endmodule

// File: tb/tb_cpu_mobo_master.sv
// Randomized self-checking bench for cpu_mobo_master: a behavioural mobo responder plus a
// per-burst transaction model (expected addresses, write data, read data and pulses).
module tb_cpu_mobo_master;
   import mobo_master_pkg::*;

   localparam int WW = 8;
   localparam int LW = 4;
   localparam int TO = 15;

   localparam logic [WW-1:0] C_NONE  = WW'(CTRL_NONE);
   localparam logic [WW-1:0] C_READ  = WW'(CTRL_READ);
   localparam logic [WW-1:0] C_WRITE = WW'(CTRL_WRITE);
   localparam logic [WW-1:0] S_IDLE  = WW'(STAT_IDLE);
   localparam logic [WW-1:0] S_DONE  = WW'(STAT_DONE);
   localparam logic [WW-1:0] S_BUSY  = 8'hEE;
   localparam logic [WW-1:0] RD_KEY  = 8'h5A;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid, req_ready, req_write;
   logic [WW-1:0] req_addr;
   logic [LW-1:0] req_len;
   logic          wr_valid, wr_ready;
   logic [WW-1:0] wr_data;
   logic          rsp_valid, rsp_ready, rsp_last;
   logic [WW-1:0] rsp_data;
   logic          done, err;
   logic [WW-1:0] mobo_ctrl, mobo_stat, addr_out, mobodat_out, mobodat_in;

   cpu_mobo_master #(
      .WORD_WIDTH  (WW),
      .LEN_WIDTH   (LW),
      .ADDR_STRIDE (1),
      .TIMEOUT     (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_addr    (req_addr),
      .req_len     (req_len),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_data     (wr_data),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_data    (rsp_data),
      .rsp_last    (rsp_last),
      .done        (done),
      .err         (err),
      .mobo_ctrl   (mobo_ctrl),
      .mobo_stat   (mobo_stat),
      .addr_out    (addr_out),
      .mobodat_out (mobodat_out),
      .mobodat_in  (mobodat_in)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Behavioural mobo: one logged record per ctrl assertion; reads return addr ^ RD_KEY.
   typedef struct {
      logic [WW-1:0] ctrl;
      logic [WW-1:0] addr;
      logic [WW-1:0] data;
      int            cycles;
      bit            stable;
   } acc_t;

   acc_t acc_q[$];
   acc_t cur;
   bit   hang = 1'b0;
   bit   in_acc;
   int   delay, busy_left;

   initial begin
      mobo_stat  = S_IDLE;
      mobodat_in = '0;
      in_acc     = 1'b0;
      busy_left  = 0;
      delay      = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            in_acc    = 1'b0;
            busy_left = 0;
            mobo_stat = S_IDLE;
         end else if (mobo_ctrl == C_NONE) begin
            if (in_acc) begin
               acc_q.push_back(cur);
               in_acc    = 1'b0;
               busy_left = $urandom_range(0, 3);
            end
            if (busy_left > 0) begin
               mobo_stat = S_BUSY;
               busy_left--;
            end else begin
               mobo_stat = S_IDLE;
            end
         end else begin
            if (!in_acc) begin
               in_acc     = 1'b1;
               cur.ctrl   = mobo_ctrl;
               cur.addr   = addr_out;
               cur.data   = mobodat_out;
               cur.cycles = 0;
               cur.stable = 1'b1;
               delay      = $urandom_range(0, 4);
            end else if (mobo_ctrl != cur.ctrl || addr_out != cur.addr || mobodat_out != cur.data) begin
               cur.stable = 1'b0;
            end
            cur.cycles++;
            if (!hang && delay == 0) begin
               mobo_stat  = S_DONE;
               mobodat_in = cur.addr ^ RD_KEY;
            end else begin
               mobo_stat = S_BUSY;
               if (delay > 0) delay--;
            end
         end
      end
   end

   task automatic run_burst(input bit wr, input logic [WW-1:0] base, input logic [LW-1:0] len,
                            input logic [WW-1:0] wd0, input int stall_beat, input int stall_cyc,
                            input bit wr_always, input bit expect_err);
      int            n;
      int            n_acc;
      logic [WW-1:0] wd[16];
      logic [WW-1:0] rd_got[$];
      bit            last_got[$];
      int            wi, ri, dones, errs, wr_pulses, cyc, stall_left;
      bit            prev_wr_ready;
      logic [WW-1:0] held;
      logic [WW-1:0] ea;

      n = int'(len) + 1;
      n_acc = expect_err ? 1 : n;
      foreach (wd[i]) wd[i] = WW'($urandom);
      wd[0] = wd0;
      wi = 0; ri = 0; dones = 0; errs = 0; wr_pulses = 0; cyc = 0;
      stall_left = stall_cyc;
      prev_wr_ready = 1'b0;
      held = '0;

      while (!req_ready && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check("req_ready_before_burst", req_ready, 1);
      acc_q.delete();
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = base;
      req_len   = len;
      cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (done) dones++;
         if (err)  errs++;
         if (dones > 0 || errs > 0 || cyc >= 3000) break;
         if (wr_ready && !prev_wr_ready) wr_pulses++;
         prev_wr_ready = wr_ready;
         // Garbage request traffic while busy must be ignored.
         req_valid = 1'($urandom_range(0, 1));
         req_write = 1'($urandom_range(0, 1));
         req_addr  = WW'($urandom);
         req_len   = LW'($urandom);
         wr_valid  = wr_always ? 1'b1 : 1'($urandom_range(0, 1));
         wr_data   = wd[wi % 16];
         if (wr_ready && wr_valid) wi++;
         if (rsp_valid) begin
            if (ri == stall_beat && stall_left > 0) begin
               if (stall_left == stall_cyc) held = rsp_data;
               else check("stall_rsp_data_stable", rsp_data, held);
               check("stall_ctrl_none", mobo_ctrl, C_NONE);
               rsp_ready = 1'b0;
               stall_left--;
            end else begin
               rsp_ready = ($urandom_range(0, 3) != 0);
            end
            if (rsp_ready) begin
               rd_got.push_back(rsp_data);
               last_got.push_back(rsp_last);
               ri++;
            end
         end else begin
            rsp_ready = 1'($urandom_range(0, 1));
         end
      end
      req_valid = 1'b0;
      wr_valid  = 1'b0;
      rsp_ready = 1'b0;
      check("burst_terminates", cyc < 3000, 1);

      @(negedge clk);
      check("done_count", dones, expect_err ? 0 : 1);
      check("err_count", errs, expect_err ? 1 : 0);
      check("pulses_single_cycle", {done, err}, 2'b00);
      check("req_ready_after", req_ready, 1);
      check("ctrl_none_after", mobo_ctrl, C_NONE);
      check("access_count", acc_q.size(), n_acc);
      for (int i = 0; i < acc_q.size() && i < n_acc; i++) begin
         ea = base + WW'(i);
         check($sformatf("acc%0d_ctrl", i), acc_q[i].ctrl, wr ? C_WRITE : C_READ);
         check($sformatf("acc%0d_addr", i), acc_q[i].addr, ea);
         check($sformatf("acc%0d_stable", i), acc_q[i].stable, 1);
         if (wr) check($sformatf("acc%0d_wdata", i), acc_q[i].data, wd[i]);
         if (expect_err) check("timeout_ctrl_cycles", acc_q[i].cycles, TO + 1);
      end
      if (wr) begin
         check("wr_ready_pulses", wr_pulses, n_acc);
         check("wr_beats_taken", wi, n_acc);
      end else begin
         check("rsp_count", rd_got.size(), expect_err ? 0 : n);
         for (int i = 0; i < rd_got.size() && i < n; i++) begin
            ea = base + WW'(i);
            check($sformatf("rsp%0d_data", i), rd_got[i], ea ^ RD_KEY);
            check($sformatf("rsp%0d_last", i), last_got[i], (i == n - 1));
         end
      end
   endtask

   task automatic reset_mid_burst();
      int cyc;
      cyc = 0;
      while (!req_ready && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      acc_q.delete();
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 8'h40;
      req_len   = 4'd3;
      @(negedge clk);
      req_valid = 1'b0;
      wr_valid  = 1'b1;
      wr_data   = 8'h3C;
      cyc = 0;
      while (!(acc_q.size() >= 1 && mobo_ctrl != C_NONE) && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("reached_beat2_access", cyc < 200, 1);
      check("beat2_addr", addr_out, 8'h41);
      rst = 1'b0;
      @(negedge clk);
      check("rst_req_ready", req_ready, 0);
      check("rst_wr_ready", wr_ready, 0);
      check("rst_rsp", {rsp_valid, rsp_last, rsp_data}, '0);
      check("rst_pulses", {done, err}, 2'b00);
      check("rst_ctrl", mobo_ctrl, C_NONE);
      check("rst_addr_out", addr_out, 0);
      check("rst_mobodat_out", mobodat_out, 0);
      rst = 1'b1;
      wr_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("no_pulse_after_rst", {done, err, mobo_ctrl != C_NONE}, 3'b000);
      end
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_len   = '0;
      wr_valid  = 1'b0;
      wr_data   = '0;
      rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_req_ready", req_ready, 0);
      check("reset_ctrl", mobo_ctrl, C_NONE);
      check("reset_outputs", {wr_ready, rsp_valid, rsp_last, done, err, addr_out, mobodat_out}, '0);
      rst = 1'b1;
      @(negedge clk);
      check("req_ready_after_reset", req_ready, 1);

      run_burst(1'b1, 8'h10, 4'd0, 8'hA5, -1, 0, 1'b1, 1'b0);
      run_burst(1'b0, 8'h20, 4'd3, 8'h00, -1, 0, 1'b0, 1'b0);
      run_burst(1'b0, 8'h30, 4'd3, 8'h00, 1, 5, 1'b0, 1'b0);
      hang = 1'b1;
      run_burst(1'b1, 8'h50, 4'd2, 8'h77, -1, 0, 1'b1, 1'b1);
      run_burst(1'b0, 8'h60, 4'd1, 8'h00, -1, 0, 1'b0, 1'b1);
      hang = 1'b0;
      reset_mid_burst();
      run_burst(1'b1, 8'h44, 4'd3, 8'h96, -1, 0, 1'b0, 1'b0);
      run_burst(1'b1, 8'hFF, 4'd1, 8'h12, -1, 0, 1'b1, 1'b0);
      run_burst(1'b0, 8'hF8, 4'd15, 8'h00, -1, 0, 1'b0, 1'b0);

      for (int k = 0; k < 20; k++) begin
         logic [LW-1:0] l;
         l = LW'($urandom);
         run_burst(1'($urandom_range(0, 1)), WW'($urandom), l, WW'($urandom),
                   $urandom_range(0, int'(l)), $urandom_range(0, 6), 1'b0, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
